// File: rtl/reg_bus_arbiter_pkg.sv
// Shared definitions for the PWM register-bank arbiter: widths, address limit,
// FSM state encoding and owner encoding.
package reg_bus_arbiter_pkg;
  localparam int         ADDR_W_DEF   = 6;
  localparam int         DATA_W_DEF   = 8;
  localparam logic [5:0] MAX_ADDR_DEF = 6'h3F;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDWAIT = 2'd2
  } state_t;

  function automatic logic other_owner(input logic own);
    return ~own;
  endfunction
endpackage

// File: rtl/reg_bus_arbiter_if.sv
// Bundle of the two master ports plus the shared register-bank port.
// slave = arbiter side, master = requesters and bank side.
interface reg_bus_arbiter_if
  import reg_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              a_req, a_we, a_gnt, a_rvalid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              b_req, b_we, b_gnt, b_rvalid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              read, write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_write;
  logic [DATA_W-1:0] data_read;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  data_read,
    output a_gnt, a_rvalid, b_gnt, b_rvalid,
    output rdata, err, read, write, addr, data_write
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output data_read,
    input  a_gnt, a_rvalid, b_gnt, b_rvalid,
    input  rdata, err, read, write, addr, data_write
  );
endinterface

// File: rtl/reg_bus_arbiter_rr_arb2.sv
// Two-way round-robin picker: combinational pick, registered priority pointer.
// On advance the pointer moves to the port that was not picked.
module rr_arb2
  import reg_bus_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       pick
);
  logic ptr;

  always_comb begin
    case (req)
      2'b01:   pick = OWN_A;
      2'b10:   pick = OWN_B;
      default: pick = ptr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= OWN_A;
    else if (advance) ptr <= other_owner(pick);
  end
endmodule

// File: rtl/reg_bus_arbiter.sv
// Shares one register-bank port between two masters with round-robin
// arbitration, one access in flight, and blocking of out-of-range addresses.
module reg_bus_arbiter
  import reg_bus_arbiter_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] MAX_ADDR = MAX_ADDR_DEF
) (
  input logic               clk,
  input logic               rst_n,
  reg_bus_arbiter_if.slave  bus
);
  logic [1:0]             req, we;
  logic [1:0][ADDR_W-1:0] p_addr;
  logic [1:0][DATA_W-1:0] p_wdata;

  assign req     = {bus.b_req,   bus.a_req};
  assign we      = {bus.b_we,    bus.a_we};
  assign p_addr  = {bus.b_addr,  bus.a_addr};
  assign p_wdata = {bus.b_wdata, bus.a_wdata};

  state_t            state, state_nx;
  logic              pick, take, pick_bad;
  logic              owner_q, we_q, bad_q;
  logic [1:0]        gnt_q, gnt_d, rvalid_q, rvalid_d;
  logic              err_q, err_d, read_q, read_d, write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dw_q, dw_d, rdata_hold, rdata_mux;

  assign take     = (state == ST_IDLE) && (|req);
  assign pick_bad = p_addr[pick] > MAX_ADDR;

  rr_arb2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (take),
    .pick    (pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Illegal reads still pass through RDWAIT so the owner gets its rvalid.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (|req) state_nx = ST_ACCESS;
      ST_ACCESS: state_nx = we_q ? ST_IDLE : ST_RDWAIT;
      ST_RDWAIT: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Next-cycle values of the registered outputs.
  always_comb begin
    gnt_d    = '0;
    rvalid_d = '0;
    err_d    = 1'b0;
    read_d   = 1'b0;
    write_d  = 1'b0;
    addr_d   = addr_q;
    dw_d     = dw_q;
    if (take) begin
      gnt_d[pick] = 1'b1;
      write_d     = we[pick] && !pick_bad;
      read_d      = !we[pick] && !pick_bad;
      err_d       = pick_bad;
      addr_d      = p_addr[pick];
      if (we[pick]) dw_d = p_wdata[pick];
    end
    if (state == ST_ACCESS && !we_q) rvalid_d[owner_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      err_q    <= 1'b0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      dw_q     <= '0;
      owner_q  <= OWN_A;
      we_q     <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      read_q   <= read_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      dw_q     <= dw_d;
      if (take) begin
        owner_q <= pick;
        we_q    <= we[pick];
        bad_q   <= pick_bad;
      end
    end
  end

  // rdata passes the bank data straight through in RDWAIT and holds otherwise.
  assign rdata_mux = (state == ST_RDWAIT) ? (bad_q ? '0 : bus.data_read) : rdata_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  rdata_hold <= '0;
    else if (state == ST_RDWAIT) rdata_hold <= rdata_mux;
  end

  assign bus.a_gnt      = gnt_q[OWN_A];
  assign bus.b_gnt      = gnt_q[OWN_B];
  assign bus.a_rvalid   = rvalid_q[OWN_A];
  assign bus.b_rvalid   = rvalid_q[OWN_B];
  assign bus.err        = err_q;
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.addr       = addr_q;
  assign bus.data_write = dw_q;
  assign bus.rdata      = rdata_mux;
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter: directed accesses push expected grants
// and read returns; a negedge monitor pops and compares as the DUT presents them.
module tb_reg_bus_arbiter;
  logic clk, rst_n;
  int   total, bad;

  reg_bus_arbiter_if #(.ADDR_W(6), .DATA_W(8)) bus ();

  reg_bus_arbiter #(.ADDR_W(6), .DATA_W(8), .MAX_ADDR(6'h10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: registered read data, valid the cycle after the read strobe.
  logic [7:0] mem [64];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(i) ^ 8'hC3;
    mem[3] = 8'h5A;
  end
  always @(posedge clk) begin
    if (bus.write) mem[bus.addr] <= bus.data_write;
    if (bus.read)  bus.data_read <= mem[bus.addr];
  end

  typedef struct {
    bit         port;
    bit         we;
    logic [5:0] addr;
    logic [7:0] wdata;
    bit         err;
  } gexp_t;
  typedef struct {
    bit         port;
    logic [7:0] data;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  bit    prev_rd;

  always @(negedge clk) begin
    gexp_t g;
    rexp_t r;
    bit    gp, want_wr, want_rd;
    total++;
    if (bus.read && bus.write) begin
      bad++;
      $display("FAIL overlap: read=%0d write=%0d, want not both", bus.read, bus.write);
    end
    if (!rst_n) prev_rd = 1'b0;
    else begin
      if (bus.a_rvalid || bus.b_rvalid) begin
        total++;
        if (rq.size() == 0 || !prev_rd || (bus.a_rvalid && bus.b_rvalid)) begin
          bad++;
          $display("FAIL rvalid_unexp: a=%0d b=%0d prev_rd=%0d queued=%0d, want none",
                   bus.a_rvalid, bus.b_rvalid, prev_rd, rq.size());
        end else begin
          r = rq.pop_front();
          if (bus.b_rvalid != r.port || bus.rdata !== r.data) begin
            bad++;
            $display("FAIL rvalid: got port=%0d rdata=%h, want port=%0d rdata=%h",
                     bus.b_rvalid, bus.rdata, r.port, r.data);
          end
        end
      end
      prev_rd = 1'b0;
      if (bus.a_gnt || bus.b_gnt) begin
        total++;
        if (gq.size() == 0 || (bus.a_gnt && bus.b_gnt)) begin
          bad++;
          $display("FAIL gnt_unexp: a=%0d b=%0d queued=%0d, want none",
                   bus.a_gnt, bus.b_gnt, gq.size());
        end else begin
          g = gq.pop_front();
          gp = bus.b_gnt;
          want_wr = g.we && !g.err;
          want_rd = !g.we && !g.err;
          prev_rd = !g.we;
          if (gp != g.port || bus.write != want_wr || bus.read != want_rd ||
              bus.err != g.err || bus.addr !== g.addr ||
              (want_wr && bus.data_write !== g.wdata)) begin
            bad++;
            $display("FAIL grant: got port=%0d rd=%0d wr=%0d err=%0d addr=%h dw=%h, want port=%0d rd=%0d wr=%0d err=%0d addr=%h dw=%h",
                     gp, bus.read, bus.write, bus.err, bus.addr, bus.data_write,
                     g.port, want_rd, want_wr, g.err, g.addr, g.wdata);
          end
        end
      end else if (bus.err || bus.read || bus.write) begin
        total++;
        bad++;
        $display("FAIL stray_strobe: err=%0d read=%0d write=%0d, want 0", bus.err, bus.read, bus.write);
      end
    end
  end

  // Called just after a rising edge; returns the number of edges until gnt.
  task automatic access(input bit p, input bit we, input logic [5:0] a,
                        input logic [7:0] d, output int n);
    bit g;
    if (!p) begin
      bus.a_we = we; bus.a_addr = a; bus.a_wdata = d; bus.a_req = 1'b1;
    end else begin
      bus.b_we = we; bus.b_addr = a; bus.b_wdata = d; bus.b_req = 1'b1;
    end
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      g = p ? bus.b_gnt : bus.a_gnt;
    end while (!g && n < 40);
    if (!g) begin
      total++; bad++;
      $display("FAIL gnt_timeout: port=%0d edges=%0d, want gnt", p, n);
    end
    if (!p) bus.a_req = 1'b0;
    else    bus.b_req = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((gq.size() != 0 || rq.size() != 0) && n < 100) begin
      @(posedge clk); n++;
    end
    if (gq.size() != 0 || rq.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: grants_left=%0d reads_left=%0d, want 0", gq.size(), rq.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.err,
            bus.read, bus.write, 3'b0, bus.addr, bus.data_write, bus.rdata};
  endfunction

  initial begin
    int n;
    total = 0; bad = 0;
    rst_n = 1'b0;
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", out_vec(), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", out_vec(), 32'h0);

    // 1: A write 0F <= AB
    gq.push_back('{0, 1, 6'h0F, 8'hAB, 0});
    access(0, 1, 6'h0F, 8'hAB, n);
    check("t1_gnt_latency", n, 1);
    @(posedge clk); #1;
    check("t1_idle_after", {bus.write, bus.a_gnt, bus.read}, 0);
    wait_drain();

    // 2: B read 03 -> 5A
    gq.push_back('{1, 0, 6'h03, 8'h00, 0});
    rq.push_back('{1, 8'h5A});
    access(1, 0, 6'h03, 8'h00, n);
    check("t2_gnt_latency", n, 1);
    wait_drain();

    // 3: both held from reset, four writes, grants alternate A,B,A,B
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    gq.push_back('{0, 1, 6'h01, 8'h11, 0});
    gq.push_back('{1, 1, 6'h02, 8'h22, 0});
    gq.push_back('{0, 1, 6'h05, 8'h55, 0});
    gq.push_back('{1, 1, 6'h06, 8'h66, 0});
    fork
      begin
        int na;
        access(0, 1, 6'h01, 8'h11, na);
        access(0, 1, 6'h05, 8'h55, na);
      end
      begin
        int nb;
        access(1, 1, 6'h02, 8'h22, nb);
        access(1, 1, 6'h06, 8'h66, nb);
      end
    join
    wait_drain();

    // 4: illegal read 20 (> 10): err, no strobe, rdata forced 00
    gq.push_back('{0, 0, 6'h20, 8'h00, 1});
    rq.push_back('{0, 8'h00});
    access(0, 0, 6'h20, 8'h00, n);
    wait_drain();

    // 5: A read 0F (AB from test 1); B write arrives during A's RDWAIT
    gq.push_back('{0, 0, 6'h0F, 8'h00, 0});
    rq.push_back('{0, 8'hAB});
    gq.push_back('{1, 1, 6'h07, 8'h3C, 0});
    access(0, 0, 6'h0F, 8'h00, n);
    @(posedge clk); #1;
    access(1, 1, 6'h07, 8'h3C, n);
    check("t5_b_wait", n, 2);
    wait_drain();
    check("t5_b_written", mem[7], 8'h3C);

    // 6: reset during ACCESS of a read drops strobes, no rvalid follows
    bus.a_we = 0; bus.a_addr = 6'h03; bus.a_req = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!bus.a_gnt && n < 40);
    check("t6_read_before_rst", {bus.a_gnt, bus.read}, 2'b11);
    rst_n = 1'b0;
    #1 check("t6_drop_on_rst", {bus.a_gnt, bus.read, bus.a_rvalid}, 3'b000);
    bus.a_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    gq.push_back('{0, 0, 6'h03, 8'h00, 0});
    rq.push_back('{0, 8'h5A});
    access(0, 0, 6'h03, 8'h00, n);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
